// File: rtl/fft_pingpong_sequencer.sv
// fft_pingpong_sequencer: runs all radix-2 stages over a ping-pong working memory,
// streaming butterfly read addresses and in-place writes, host pass-through while idle.
module fft_pingpong_sequencer #(
    parameter int N          = 1024,
    parameter int ADDR_WIDTH = $clog2(N),
    parameter int PIPE_LAT   = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            i_start,
    input  logic [ADDR_WIDTH-1:0]           i_fmt_cfg,
    input  logic [ADDR_WIDTH-1:0]           i_host_rd_addr,
    input  logic                            i_host_wr_en,
    input  logic [ADDR_WIDTH-1:0]           i_host_wr_addr,
    input  logic [15:0]                     i_host_wr_data,
    input  logic                            i_host_fmt,
    input  logic [15:0]                     i_dp_wr_data,
    output logic                            o_mem_bank_sel,
    output logic                            o_mem_format_mode,
    output logic [ADDR_WIDTH-1:0]           o_mem_rd_addr,
    output logic                            o_mem_wr_en,
    output logic [ADDR_WIDTH-1:0]           o_mem_wr_addr,
    output logic [15:0]                     o_mem_wr_data,
    output logic                            o_dp_in_valid,
    output logic                            o_dp_elem,
    output logic [ADDR_WIDTH-2:0]           o_tw_idx,
    output logic [$clog2(ADDR_WIDTH)-1:0]   o_stage_idx,
    output logic                            o_busy,
    output logic                            o_done
);
    localparam int SW = $clog2(ADDR_WIDTH);
    localparam int DW = $clog2(PIPE_LAT);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

    state_t                               r_state;
    state_t                               w_state_nxt;
    logic [ADDR_WIDTH-1:0]                r_k;
    logic [SW-1:0]                        r_stage;
    logic [DW-1:0]                        r_dcnt;
    logic                                 r_bank;
    logic [ADDR_WIDTH-1:0]                r_fmt;
    logic [PIPE_LAT-1:0]                  r_dv;
    logic [PIPE_LAT-1:0][ADDR_WIDTH-1:0]  r_da;
    logic                                 r_in_valid;
    logic                                 r_elem;
    logic [ADDR_WIDTH-2:0]                r_tw;
    logic                                 r_done;

    logic                                 w_idle;
    logic                                 w_issue;
    logic                                 w_start;
    logic                                 w_last_k;
    logic                                 w_drain_end;
    logic                                 w_last_stage;
    logic                                 w_stage_end;
    logic [ADDR_WIDTH-1:0]                w_b;
    logic                                 w_e;
    logic [ADDR_WIDTH-1:0]                w_sh;
    logic [ADDR_WIDTH-1:0]                w_mask;
    logic [ADDR_WIDTH-1:0]                w_rd_addr;
    logic [ADDR_WIDTH-2:0]                w_tw;

    assign w_idle       = r_state == S_IDLE;
    assign w_issue      = r_state == S_RUN;
    assign w_start      = w_idle && i_start;
    assign w_last_k     = r_k == ADDR_WIDTH'(N - 1);
    assign w_drain_end  = r_dcnt == DW'(PIPE_LAT - 1);
    assign w_last_stage = r_stage == SW'(ADDR_WIDTH - 1);
    assign w_stage_end  = (r_state == S_DRAIN) && w_drain_end;

    // Element bit e is inserted at bit log2(span) = ADDR_WIDTH-1-stage of the butterfly index.
    always_comb begin
        w_b       = {1'b0, r_k[ADDR_WIDTH-1:1]};
        w_e       = r_k[0];
        w_sh      = ADDR_WIDTH'(ADDR_WIDTH - 1) - ADDR_WIDTH'(r_stage);
        w_mask    = (ADDR_WIDTH'(1) << w_sh) - ADDR_WIDTH'(1);
        w_rd_addr = ((w_b >> w_sh) << (w_sh + ADDR_WIDTH'(1))) | (ADDR_WIDTH'(w_e) << w_sh) | (w_b & w_mask);
        w_tw      = (ADDR_WIDTH-1)'((w_b & w_mask) << r_stage);
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  w_state_nxt = i_start ? S_RUN : S_IDLE;
            S_RUN:   w_state_nxt = w_last_k ? S_DRAIN : S_RUN;
            S_DRAIN: w_state_nxt = w_drain_end ? (w_last_stage ? S_IDLE : S_RUN) : S_DRAIN;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_k        <= '0;
            r_stage    <= '0;
            r_dcnt     <= '0;
            r_bank     <= 1'b0;
            r_fmt      <= '0;
            r_dv       <= '0;
            r_da       <= '0;
            r_in_valid <= 1'b0;
            r_elem     <= 1'b0;
            r_tw       <= '0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_k        <= w_issue ? r_k + ADDR_WIDTH'(1) : '0;
            r_dcnt     <= (r_state == S_DRAIN && !w_drain_end) ? r_dcnt + DW'(1) : '0;
            r_done     <= w_stage_end && w_last_stage;
            r_dv       <= {r_dv[PIPE_LAT-2:0], w_issue};
            r_da       <= {r_da[PIPE_LAT-2:0], w_rd_addr};
            r_in_valid <= w_issue;
            r_elem     <= w_issue && w_e;
            r_tw       <= w_issue ? w_tw : '0;
            if (w_start) begin
                r_bank  <= ~r_bank;
                r_fmt   <= i_fmt_cfg;
                r_stage <= '0;
            end else if (w_stage_end) begin
                r_bank  <= ~r_bank;
                r_stage <= w_last_stage ? '0 : r_stage + SW'(1);
            end
        end
    end

    assign o_mem_bank_sel    = r_bank;
    assign o_mem_format_mode = w_idle ? i_host_fmt : r_fmt[r_stage];
    assign o_mem_rd_addr     = w_idle ? i_host_rd_addr : w_rd_addr;
    assign o_mem_wr_en       = w_idle ? i_host_wr_en : r_dv[PIPE_LAT-1];
    assign o_mem_wr_addr     = w_idle ? i_host_wr_addr : r_da[PIPE_LAT-1];
    assign o_mem_wr_data     = w_idle ? i_host_wr_data : i_dp_wr_data;
    assign o_dp_in_valid     = r_in_valid;
    assign o_dp_elem         = r_elem;
    assign o_tw_idx          = r_tw;
    assign o_stage_idx       = r_stage;
    assign o_busy            = !w_idle;
    assign o_done            = r_done;
endmodule

// File: tb/tb_fft_pingpong_sequencer.sv
// tb_fft_pingpong_sequencer: N=8, PIPE_LAT=2 bench with a formula-based reference model
// of the FFT addressing, bank ping-pong and a two-bank memory scoreboard.
module tb_fft_pingpong_sequencer;
    localparam int N  = 8;
    localparam int AW = 3;
    localparam int PL = 2;
    localparam int SL = N + PL;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          i_start = 1'b0;
    logic [AW-1:0] i_fmt_cfg = '0;
    logic [AW-1:0] i_host_rd_addr = '0;
    logic          i_host_wr_en = 1'b0;
    logic [AW-1:0] i_host_wr_addr = '0;
    logic [15:0]   i_host_wr_data = '0;
    logic          i_host_fmt = 1'b0;
    logic [15:0]   i_dp_wr_data = '0;
    logic          o_mem_bank_sel, o_mem_format_mode, o_mem_wr_en;
    logic [AW-1:0] o_mem_rd_addr, o_mem_wr_addr;
    logic [15:0]   o_mem_wr_data;
    logic          o_dp_in_valid, o_dp_elem, o_busy, o_done;
    logic [AW-2:0] o_tw_idx;
    logic [1:0]    o_stage_idx;

    int   errors = 0;
    int   checks = 0;
    logic bank_ref = 1'b0;
    logic [15:0] ref_mem [2][N];
    logic [15:0] dut_mem [2][N];

    always #5 clk = ~clk;

    fft_pingpong_sequencer #(.N(N), .PIPE_LAT(PL)) dut (
        .clk(clk), .rst(rst), .i_start(i_start), .i_fmt_cfg(i_fmt_cfg),
        .i_host_rd_addr(i_host_rd_addr), .i_host_wr_en(i_host_wr_en),
        .i_host_wr_addr(i_host_wr_addr), .i_host_wr_data(i_host_wr_data),
        .i_host_fmt(i_host_fmt), .i_dp_wr_data(i_dp_wr_data),
        .o_mem_bank_sel(o_mem_bank_sel), .o_mem_format_mode(o_mem_format_mode),
        .o_mem_rd_addr(o_mem_rd_addr), .o_mem_wr_en(o_mem_wr_en),
        .o_mem_wr_addr(o_mem_wr_addr), .o_mem_wr_data(o_mem_wr_data),
        .o_dp_in_valid(o_dp_in_valid), .o_dp_elem(o_dp_elem), .o_tw_idx(o_tw_idx),
        .o_stage_idx(o_stage_idx), .o_busy(o_busy), .o_done(o_done)
    );

    function automatic int exp_addr(int s, int k);
        int b    = k / 2;
        int span = N >> (s + 1);
        return (b / span) * 2 * span + (b % span) + (k % 2) * span;
    endfunction

    function automatic int exp_tw(int s, int k);
        int span = N >> (s + 1);
        return ((k / 2) % span) << s;
    endfunction

    task automatic test_reset;
        rst = 1'b0;
        #1;
        checks++; if (o_mem_bank_sel !== 1'b0) begin errors++; $display("FAIL reset bank_sel got %b want 0", o_mem_bank_sel); end
        checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL reset busy got %b want 0", o_busy); end
        checks++; if (o_done !== 1'b0) begin errors++; $display("FAIL reset done got %b want 0", o_done); end
        checks++; if (o_stage_idx !== 2'd0) begin errors++; $display("FAIL reset stage got %0d want 0", o_stage_idx); end
        checks++; if (o_dp_in_valid !== 1'b0 || o_dp_elem !== 1'b0 || o_tw_idx !== 2'd0) begin errors++; $display("FAIL reset dp got v%b e%b tw%0d want 0", o_dp_in_valid, o_dp_elem, o_tw_idx); end
        checks++; if (o_mem_wr_en !== 1'b0) begin errors++; $display("FAIL reset wr_en got %b want 0", o_mem_wr_en); end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        bank_ref = 1'b0;
    endtask

    task automatic test_host;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            i_host_rd_addr = AW'($urandom);
            i_host_wr_en   = 1'($urandom);
            i_host_wr_addr = AW'($urandom);
            i_host_wr_data = 16'($urandom);
            i_host_fmt     = 1'($urandom);
            i_dp_wr_data   = 16'($urandom);
            #1;
            checks++;
            if (o_mem_rd_addr !== i_host_rd_addr || o_mem_wr_en !== i_host_wr_en || o_mem_wr_addr !== i_host_wr_addr ||
                o_mem_wr_data !== i_host_wr_data || o_mem_format_mode !== i_host_fmt || o_busy !== 1'b0)
            begin
                errors++;
                $display("FAIL host_pass c%0d got ra%0d we%b wa%0d wd%h f%b busy%b want ra%0d we%b wa%0d wd%h f%b busy0",
                         c, o_mem_rd_addr, o_mem_wr_en, o_mem_wr_addr, o_mem_wr_data, o_mem_format_mode, o_busy,
                         i_host_rd_addr, i_host_wr_en, i_host_wr_addr, i_host_wr_data, i_host_fmt);
            end
            checks++; if (o_mem_bank_sel !== bank_ref) begin errors++; $display("FAIL host_bank got %b want %b", o_mem_bank_sel, bank_ref); end
        end
        @(negedge clk);
        i_host_wr_en = 1'b0;
    endtask

    task automatic test_run(input logic [AW-1:0] fmt, input bit hold, input bit scramble);
        logic [15:0] d;
        logic        eb;
        logic        fin;
        int          s, j, k;
        for (int b = 0; b < 2; b++) for (int a = 0; a < N; a++) begin ref_mem[b][a] = '0; dut_mem[b][a] = '0; end
        @(negedge clk);
        i_fmt_cfg    = fmt;
        i_start      = 1'b1;
        i_host_wr_en = 1'b0;
        fin          = bank_ref ^ 1'b1 ^ 1'(AW % 2);
        for (int c = 0; c < AW * SL + 2; c++) begin
            @(negedge clk);
            i_start = hold && (c < AW * SL);
            if (scramble) i_fmt_cfg = AW'($urandom);
            d = 16'($urandom);
            i_dp_wr_data = d;
            #1;
            if (o_mem_wr_en === 1'b1 && o_mem_bank_sel !== 1'bx && !$isunknown(o_mem_wr_addr))
                dut_mem[~o_mem_bank_sel][o_mem_wr_addr] = o_mem_wr_data;
            if (c < AW * SL) begin
                s  = c / SL;
                j  = c % SL;
                eb = bank_ref ^ 1'b1 ^ 1'(s % 2);
                checks++; if (o_busy !== 1'b1 || o_done !== 1'b0) begin errors++; $display("FAIL run_busy c%0d got busy%b done%b want 1 0", c, o_busy, o_done); end
                checks++; if (o_stage_idx !== 2'(s)) begin errors++; $display("FAIL stage c%0d got %0d want %0d", c, o_stage_idx, s); end
                checks++; if (o_mem_bank_sel !== eb) begin errors++; $display("FAIL bank c%0d got %b want %b", c, o_mem_bank_sel, eb); end
                checks++; if (o_mem_format_mode !== fmt[s]) begin errors++; $display("FAIL fmt c%0d got %b want %b", c, o_mem_format_mode, fmt[s]); end
                if (j < N) begin
                    checks++; if (o_mem_rd_addr !== AW'(exp_addr(s, j))) begin errors++; $display("FAIL rd_addr s%0d k%0d got %0d want %0d", s, j, o_mem_rd_addr, exp_addr(s, j)); end
                end
                checks++; if (o_dp_in_valid !== (j >= 1 && j <= N)) begin errors++; $display("FAIL dp_valid c%0d got %b", c, o_dp_in_valid); end
                if (j >= 1 && j <= N) begin
                    k = j - 1;
                    checks++; if (o_dp_elem !== 1'(k % 2) || o_tw_idx !== 2'(exp_tw(s, k))) begin errors++; $display("FAIL dp_op s%0d k%0d got e%b tw%0d want e%0d tw%0d", s, k, o_dp_elem, o_tw_idx, k % 2, exp_tw(s, k)); end
                end
                checks++; if (o_mem_wr_en !== (j >= PL && j < N + PL)) begin errors++; $display("FAIL wr_en c%0d got %b", c, o_mem_wr_en); end
                if (j >= PL && j < N + PL) begin
                    k = j - PL;
                    checks++; if (o_mem_wr_addr !== AW'(exp_addr(s, k))) begin errors++; $display("FAIL wr_addr s%0d k%0d got %0d want %0d", s, k, o_mem_wr_addr, exp_addr(s, k)); end
                    ref_mem[~eb][exp_addr(s, k)] = d;
                end
                checks++; if (o_mem_wr_data !== d) begin errors++; $display("FAIL wr_data c%0d got %h want %h", c, o_mem_wr_data, d); end
            end else begin
                checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL end_busy c%0d got %b want 0", c, o_busy); end
                checks++; if (o_done !== (c == AW * SL)) begin errors++; $display("FAIL done c%0d got %b want %b", c, o_done, c == AW * SL); end
                checks++; if (o_mem_bank_sel !== fin) begin errors++; $display("FAIL final_bank got %b want %b", o_mem_bank_sel, fin); end
            end
        end
        bank_ref = fin;
        for (int b = 0; b < 2; b++) for (int a = 0; a < N; a++) begin
            checks++;
            if (dut_mem[b][a] !== ref_mem[b][a]) begin errors++; $display("FAIL mem bank%0d addr%0d got %h want %h", b, a, dut_mem[b][a], ref_mem[b][a]); end
        end
    endtask

    task automatic test_reset_mid(input int at);
        @(negedge clk);
        i_fmt_cfg = AW'($urandom);
        i_start   = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        repeat (at) @(negedge clk);
        rst = 1'b0;
        #1;
        checks++; if (o_mem_wr_en !== 1'b0) begin errors++; $display("FAIL abort_wr_en got %b want 0", o_mem_wr_en); end
        checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %b want 0", o_busy); end
        checks++; if (o_mem_bank_sel !== 1'b0) begin errors++; $display("FAIL abort_bank got %b want 0", o_mem_bank_sel); end
        checks++; if (o_done !== 1'b0) begin errors++; $display("FAIL abort_done got %b want 0", o_done); end
        @(negedge clk);
        rst = 1'b1;
        bank_ref = 1'b0;
        for (int c = 0; c < SL; c++) begin
            @(negedge clk);
            #1;
            checks++; if (o_done !== 1'b0 || o_busy !== 1'b0 || o_mem_wr_en !== 1'b0) begin errors++; $display("FAIL post_abort c%0d got done%b busy%b we%b want 0 0 0", c, o_done, o_busy, o_mem_wr_en); end
        end
    endtask

    initial begin
        test_reset();
        test_host();
        test_run(3'b000, 1'b0, 1'b0);
        test_run(3'b101, 1'b0, 1'b1);
        test_run(AW'($urandom), 1'b1, 1'b0);
        test_reset_mid(12);
        test_host();
        test_reset_mid(25);
        test_host();
        test_run(AW'($urandom), 1'b0, 1'b1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
